// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory request/ack bus and the fetch-to-decode handshake.
// The fetch stage takes the master modport; memory and decode together take the slave modport.
interface instr_fetch_if #(
   parameter int PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [7:0]      imem_rdata;
   logic            instr_valid;
   logic            instr_ready;
   logic [1:0]      op;
   logic [1:0]      rs;
   logic [1:0]      rt;
   logic [1:0]      rd_imm;
   logic [PC_W-1:0] instr_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, op, rs, rt, rd_imm, instr_pc,
      input  imem_ack, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, op, rs, rt, rd_imm, instr_pc,
      output imem_ack, imem_rdata, instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches one instruction at a time over req/ack,
// and holds it in the instruction register until decode accepts it or a branch flushes it.
module instr_fetch #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   instr_fetch_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FULL
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   logic [PC_W-1:0] instr_pc_q, instr_pc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 8'h00;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   // A redirect outranks both the memory ack and the decode handshake, so an
   // ack or accept landing in the same cycle is simply ignored.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      instr_pc_d = instr_pc_q;

      case (state_q)
         IDLE: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (run) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = run ? REQ : IDLE;
            end else if (bus.imem_ack) begin
               ir_d       = bus.imem_rdata;
               instr_pc_d = pc_q;
               pc_d       = pc_q + PC_W'(1);
               state_d    = FULL;
            end
         end
         FULL: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = run ? REQ : IDLE;
            end else if (bus.instr_ready) begin
               state_d = run ? REQ : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.imem_req    = (state_q == REQ);
   assign bus.imem_addr   = pc_q;
   assign bus.instr_valid = (state_q == FULL);
   assign bus.op          = ir_q[7:6];
   assign bus.rs          = ir_q[5:4];
   assign bus.rt          = ir_q[3:2];
   assign bus.rd_imm      = ir_q[1:0];
   assign bus.instr_pc    = instr_pc_q;

endmodule
